wb_regfile: RTL
===============

# wb_regfile

Write-back register file for the 5-stage CPU pipeline: the consumer of the MEM/WB pipeline register outputs. Selects the write-back value (ALU result or memory load data), commits it to a 32-entry general-purpose register array, and serves the two ID-stage read ports. It includes an optional same-cycle write-through bypass and a count of retired register writes.

## Interface
- XLEN, 32, data width of registers and write-back operands
- NREGS, 32, number of architectural registers (address width = $clog2(NREGS))
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- start_i  in  1  pipeline run enable; 0 freezes all state updates
- RegWrite_i  in  1  write-back enable from MEM/WB
- MemReg_i  in  1  write-back source select: 1 = data2_i (load data), 0 = data1_i (ALU result)
- rd_addr_i  in  5  destination register index
- data1_i  in  XLEN  ALU result
- data2_i  in  XLEN  memory load data
- rs1_addr_i  in  5  read port 1 index
- rs2_addr_i  in  5  read port 2 index
- rs1_data_o  out  XLEN  read port 1 data, combinational
- rs2_data_o  out  XLEN  read port 2 data, combinational
- retire_cnt_o  out  32  count of committed non-x0 register writes

## Operation
- wb_data = MemReg_i ? data2_i : data1_i.
- Commit condition: start_i && RegWrite_i && rd_addr_i != 0. On commit, at the rising edge, regs[rd_addr_i] <= wb_data and retire_cnt_o <= retire_cnt_o + 1.
- x0 is hardwired to 0. A write to x0 is dropped, is not counted, and is not bypassed. A read of x0 always returns 0.
- start_i = 0: no register or counter update regardless of other inputs. Read ports remain live.
- retire_cnt_o wraps from 0xFFFF_FFFF to 0 without saturation or flag.
- Reads are purely combinational from the array (plus the bypass, if compiled in). The two ports are independent; both may address the same register.

## Timing
- Reset (asynchronous): all NREGS entries = 0, retire_cnt_o = 0. Consequently rs1_data_o = rs2_data_o = 0 while rst_i is high.
- Reset mid-operation clears state immediately. A commit coinciding with the rst_i assertion edge is lost.
- Write latency: the value is visible in the array one clock after the commit cycle.
- Same-cycle read of the register being committed:
  - With bypass: returns wb_data in the commit cycle.
  - Without bypass: returns the old value; the new value appears after the edge.
- Back-to-back commits to the same rd: the last one wins, and each commit increments the counter.
- The combinational path rd/data/MemReg -> rs*_data_o exists only with bypass enabled.

## Configuration
- WB_BYPASS_EN defined: read ports return wb_data when the commit condition holds and rs*_addr_i == rd_addr_i. This removes the WB->ID hazard, so the hazard unit needs no WB stall.
- WB_BYPASS_EN undefined: reads return array contents only. The hazard/forwarding unit must cover the WB->ID distance.

## Structure
- Shared package cpu_pkg holds:
  - XLEN and REG_ADDR_W (5) constants
  - NREGS constant
  - REG_ZERO constant (5'd0)
  - the reg_addr_t and xword_t typedefs
- One sub-module: wb_select, the combinational MemReg_i mux producing wb_data. It is reused by the forwarding unit.
- Array, counter, and bypass logic live in wb_regfile.

## Test plan
- Reset: assert rst_i mid-run after writing x5 = 0x1234 -> rs1_data_o(x5) = 0 immediately, retire_cnt_o = 0.
- ALU write-back: start_i = 1, RegWrite_i = 1, MemReg_i = 0, rd = 7, data1 = 0xDEADBEEF, data2 = 0x1 -> next cycle x7 = 0xDEADBEEF, retire_cnt_o = 1.
- Load write-back and x0: MemReg_i = 1, rd = 3, data2 = 0xCAFE0000 -> x3 = 0xCAFE0000. Then rd = 0, data1 = 0xFFFFFFFF -> x0 reads 0 and the counter is unchanged.
- Freeze: start_i = 0, RegWrite_i = 1, rd = 9, data1 = 0x55 -> x9 stays 0 and the counter is unchanged. Raise start_i -> x9 = 0x55 after the edge.
- Bypass: commit rd = 4, data1 = 0xA5A5A5A5 while rs1 = rs2 = 4. With WB_BYPASS_EN both ports read 0xA5A5A5A5 in the same cycle; without it both read the old value (0), then 0xA5A5A5A5 next cycle.
- Counter wrap: preload the counter via 2^32 − 1 commits (or a bench force to 0xFFFFFFFF), then one commit -> retire_cnt_o = 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants and types: register file geometry and word type.
package cpu_pkg;

  localparam int XLEN       = 32;
  localparam int NREGS      = 32;
  localparam int REG_ADDR_W = $clog2(NREGS);

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xword_t;

  localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/wb_regfile_if.sv
// MEM/WB write-back bus plus the two ID-stage read ports of the register file.
interface wb_regfile_if;
  import cpu_pkg::*;

  logic      RegWrite_i;
  logic      MemReg_i;
  reg_addr_t rd_addr_i;
  xword_t    data1_i;
  xword_t    data2_i;
  reg_addr_t rs1_addr_i;
  reg_addr_t rs2_addr_i;
  xword_t    rs1_data_o;
  xword_t    rs2_data_o;

  // Pipeline side: drives write-back and read addresses, receives read data.
  modport master (
    output RegWrite_i, MemReg_i, rd_addr_i, data1_i, data2_i,
    output rs1_addr_i, rs2_addr_i,
    input  rs1_data_o, rs2_data_o
  );

  // Register file side.
  modport slave (
    input  RegWrite_i, MemReg_i, rd_addr_i, data1_i, data2_i,
    input  rs1_addr_i, rs2_addr_i,
    output rs1_data_o, rs2_data_o
  );

endinterface

// File: rtl/wb_select.sv
// Write-back source mux: load data when mem_reg_i is set, ALU result otherwise.
// Purely combinational so the forwarding unit can reuse it.
module wb_select
  import cpu_pkg::*;
(
  input  logic   mem_reg_i,
  input  xword_t data1_i,
  input  xword_t data2_i,
  output xword_t wb_data_o
);

  // Select the value that will be committed to the register array.
  always_comb begin
    wb_data_o = data1_i;
    if (mem_reg_i) wb_data_o = data2_i;
  end

endmodule

// File: rtl/wb_regfile.sv
// Write-back register file: commits the MEM/WB result into a 32-entry array,
// serves two combinational read ports and counts retired (non-x0) writes.
// Optional macro WB_BYPASS_EN: read ports return the value being committed in
// the same cycle when their address matches the destination register.
module wb_regfile
  import cpu_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  wb_regfile_if.slave   wb,
  output logic [31:0]   retire_cnt_o
);

  xword_t      wb_data;
  logic        commit;
  xword_t      regs_q [NREGS];
  xword_t      regs_d [NREGS];
  logic [31:0] retire_cnt_q;
  logic [31:0] retire_cnt_d;

  wb_select u_wb_select (
    .mem_reg_i (wb.MemReg_i),
    .data1_i   (wb.data1_i),
    .data2_i   (wb.data2_i),
    .wb_data_o (wb_data)
  );

  // x0 is never written, so a write to it neither commits nor bypasses.
  assign commit = start_i && wb.RegWrite_i && (wb.rd_addr_i != REG_ZERO);

  // Next array contents and retire count for the upcoming edge.
  always_comb begin
    regs_d       = regs_q;
    retire_cnt_d = retire_cnt_q;
    if (commit) begin
      regs_d[wb.rd_addr_i] = wb_data;
      retire_cnt_d         = retire_cnt_q + 32'd1;
    end
    regs_d[0] = '0;
  end

  // State registers; asynchronous reset clears the array and the counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      retire_cnt_q <= '0;
    end else begin
      regs_q       <= regs_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign retire_cnt_o = retire_cnt_q;

  // Read port 1: array lookup, x0 forced to zero, optional same-cycle bypass.
  always_comb begin
    wb.rs1_data_o = regs_q[wb.rs1_addr_i];
    if (wb.rs1_addr_i == REG_ZERO) wb.rs1_data_o = '0;
`ifdef WB_BYPASS_EN
    if (commit && (wb.rs1_addr_i == wb.rd_addr_i)) wb.rs1_data_o = wb_data;
`endif
  end

  // Read port 2: same behaviour as port 1, independent address.
  always_comb begin
    wb.rs2_data_o = regs_q[wb.rs2_addr_i];
    if (wb.rs2_addr_i == REG_ZERO) wb.rs2_data_o = '0;
`ifdef WB_BYPASS_EN
    if (commit && (wb.rs2_addr_i == wb.rd_addr_i)) wb.rs2_data_o = wb_data;
`endif
  end

endmodule
